// File: rtl/host_tx_arbiter.sv
// host_tx_arbiter: packet-aware round-robin arbiter merging NUM_REQ byte streams onto one host stream
module host_tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int STALL_TIMEOUT = 1024,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [8*NUM_REQ-1:0] s_tdata,
  input  logic [NUM_REQ-1:0]   s_tvalid,
  input  logic [NUM_REQ-1:0]   s_tlast,
  output logic [NUM_REQ-1:0]   s_tready,
  output logic [7:0]           m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [GW-1:0]        grant_id,
  output logic                 busy,
  output logic                 stall_err
);
  localparam int CW = $clog2(STALL_TIMEOUT + 1);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state, state_nxt;
  logic [GW-1:0] grant_nxt;
  logic [GW-1:0] cand;
  logic [GW-1:0] idx;
  logic found;
  logic [CW-1:0] stall_cnt, stall_nxt;
  logic stall_err_nxt;
  assign busy = state == XFER;
  // round-robin search: first valid requester after the last grant, wrapping around
  always_comb begin
    found = 1'b0;
    cand = grant_id;
    idx = grant_id;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = GW'((int'(grant_id) + k) % NUM_REQ);
      if (!found && s_tvalid[idx]) begin
        found = 1'b1;
        cand = idx;
      end
    end
  end
  // next state, zero-latency passthrough of the granted stream, and stall watchdog
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    stall_nxt = stall_cnt;
    stall_err_nxt = stall_err;
    s_tready = '0;
    m_tvalid = 1'b0;
    m_tdata = '0;
    if (state == IDLE) begin
      if (found) begin
        state_nxt = XFER;
        grant_nxt = cand;
        stall_nxt = '0;
      end
    end else begin
      m_tvalid = s_tvalid[grant_id];
      m_tdata = s_tdata[{grant_id, 3'b000} +: 8];
      s_tready[grant_id] = m_tready;
      if (m_tvalid && m_tready) begin
        stall_nxt = '0;
        state_nxt = s_tlast[grant_id] ? IDLE : XFER;
      end else if (!m_tvalid) begin
        if (stall_cnt == CW'(STALL_TIMEOUT - 1)) begin
          stall_err_nxt = 1'b1;
          state_nxt = IDLE;
          stall_nxt = '0;
        end else begin
          stall_nxt = stall_cnt + 1'b1;
        end
      end
    end
  end
  // state, grant and watchdog registers; grant starts at the top so requester 0 wins first
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant_id <= GW'(NUM_REQ - 1);
      stall_cnt <= '0;
      stall_err <= 1'b0;
    end else begin
      state <= state_nxt;
      grant_id <= grant_nxt;
      stall_cnt <= stall_nxt;
      stall_err <= stall_err_nxt;
    end
  end
endmodule

// File: doc/host_tx_arbiter.md
Name: host_tx_arbiter

Overview:
- Packet-aware round-robin arbiter that shares the single to-host byte stream between NUM_REQ requesters (e.g. the ucaspian core response stream and a board status/debug responder).
- Sits between the requesters and the outgoing AXI-stream FIFO that feeds the FT245 bridge.
- Guarantees packets from different requesters never interleave on the host link.
- Recovers from a requester that stalls mid-packet.

Parameters:
- NUM_REQ, 2, number of requesting byte streams (2..8).
- STALL_TIMEOUT, 1024, consecutive cycles with granted s_tvalid low mid-packet before the grant is forcibly released.
- GW, $clog2(NUM_REQ) (min 1), width of grant index (localparam).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- s_tdata  input  8*NUM_REQ  requester bytes; requester i on bits [8i+7:8i].
- s_tvalid  input  NUM_REQ  per-requester valid.
- s_tlast  input  NUM_REQ  per-requester end-of-packet marker.
- s_tready  output  NUM_REQ  per-requester ready.
- m_tdata  output  8  byte to outgoing FIFO.
- m_tvalid  output  1  valid to outgoing FIFO.
- m_tready  input  1  outgoing FIFO ready.
- grant_id  output  GW  index of current/last granted requester.
- busy  output  1  high while in XFER.
- stall_err  output  1  sticky: a forced release has occurred; cleared only by reset.

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk.
- Reset values: state=IDLE, grant_id=NUM_REQ-1 (so requester 0 has first priority), busy=0, stall_err=0, stall counter=0.
  - Combinational outputs are forced low while in IDLE: s_tready=0, m_tvalid=0, m_tdata=0.
- Handshake: a beat transfers when m_tvalid && m_tready. AXI-stream rules apply.
  - m_tvalid never depends on m_tready.
- State IDLE:
  - If any s_tvalid is set, select the first requester with valid set, searching (grant_id+1) mod NUM_REQ upward with wraparound.
  - Register the selection into grant_id and go to XFER.
  - No data moves in the IDLE cycle, so arbitration latency is 1 cycle.
  - If no s_tvalid is set, stay in IDLE and leave grant_id unchanged.
- State XFER (g = grant_id):
  - m_tvalid = s_tvalid[g], m_tdata = s_tdata[g], s_tready[g] = m_tready; all other s_tready = 0. This path is combinational with zero-latency passthrough.
  - When a beat with s_tlast[g] is accepted, return to IDLE.
  - One bubble cycle between packets is the required behaviour.
  - Single-byte packets (tlast on the first beat) are legal.
- Stall counter (XFER only):
  - Increments each cycle s_tvalid[g]=0 and clears on any accepted beat.
  - Holds while s_tvalid[g]=1 and m_tready=0; downstream backpressure is never a stall.
  - Clears on entry to XFER.
  - When it reaches STALL_TIMEOUT-1 and s_tvalid[g] is still 0, set stall_err and return to IDLE (grant_id keeps g, so the next search starts after g).
  - Any remaining bytes from g arbitrate later as a new packet.
- A requester asserting valid during another's packet waits; it is never starved beyond NUM_REQ-1 packets.
- Requester valid may drop in the same cycle as arbitration. A grant to a requester whose valid then stays low is handled by the stall counter only.
- Reset mid-packet: immediate return to IDLE and all readies low on the next cycle. No partial-packet bookkeeping is retained.
- busy = (state==XFER).

Test Plan:
- Single requester: requester 0 sends a 4-byte packet 0x11,0x22,0x33,0x44 (tlast on 0x44), m_tready=1.
  - Expect grant_id=0 after 1 IDLE cycle, 4 consecutive beats out, then busy=0.
- Contention: both requesters valid continuously, each with 3-byte packets.
  - Expect the output sequence to be whole packets alternating 0,1,0,1.
  - Expect no byte of requester 1 inside a packet of requester 0, and one bubble between packets.
- Backpressure: requester 1 sends 5 bytes while m_tready toggles 1,0,0,1,...
  - Expect bytes exact and in order.
  - Expect s_tready[1] to mirror m_tready, and stall_err=0 even with m_tready low for 2000 cycles.
- Stall recovery with STALL_TIMEOUT=16: requester 0 sends 2 bytes without tlast, then drops valid; requester 1 is valid.
  - Expect stall_err=1 after 16 idle cycles, then requester 1's packet granted.
- Single-beat packets: NUM_REQ=4, all valid with tlast on every beat.
  - Expect grant order 0,1,2,3,0, each separated by one IDLE cycle.
- Reset mid-packet: assert reset during byte 2 of a 6-byte packet.
  - Expect next cycle s_tready=0, m_tvalid=0, grant_id=NUM_REQ-1, stall_err=0.
